// File: rtl/unidade_busca_pkg.sv
// -----------------------------------------------------------------------------
// unidade_busca_pkg
// Shared definitions for the instruction fetch unit: opcode encodings, the
// position of the opcode and jump-target fields inside an instruction word,
// the fetch FSM state type and small helper functions.
// -----------------------------------------------------------------------------
package unidade_busca_pkg;

    localparam logic [5:0] OPCODE_JUMP = 6'b000101;
    localparam logic [5:0] OPCODE_BEQ  = 6'b001010;
    localparam logic [5:0] OPCODE_NOP  = 6'b001100;

    // Field positions inside a 32-bit instruction word
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int ALVO_MSB = 25;
    localparam int ALVO_W   = ALVO_MSB + 1;

    typedef enum logic [1:0] {
        BUSCA  = 2'd0,
        PARADO = 2'd1,
        HALT   = 2'd2
    } estado_t;

    function automatic logic eh_jump(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OPCODE_JUMP;
    endfunction

    // Fetch counter increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] incr_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/unidade_busca_contador_programa.sv
// -----------------------------------------------------------------------------
// contador_programa
// Program counter register with its next-PC selection.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset, loads END_INICIAL
//   avanca_i     : a fetch completes this edge, advance PC
//   desvio_i     : redirect, load destino_i (priority over avanca_i)
//   destino_i    : redirect target
//   instrucao_i  : instruction at the current PC (decoded for jumps)
//   pc_o         : current PC, straight from the register
// -----------------------------------------------------------------------------
module contador_programa
    import unidade_busca_pkg::*;
#(
    parameter int          LARGURA_END = 32,
    parameter int unsigned END_INICIAL = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   avanca_i,
    input  logic                   desvio_i,
    input  logic [LARGURA_END-1:0] destino_i,
    input  logic [31:0]            instrucao_i,
    output logic [LARGURA_END-1:0] pc_o
);

    localparam logic [LARGURA_END-1:0] UM   = LARGURA_END'(1);
    localparam logic [LARGURA_END-1:0] INIC = LARGURA_END'(END_INICIAL);

    logic [LARGURA_END-1:0] pc_q, pc_d;
    logic [LARGURA_END-1:0] alvo;

    // Jump target: zero-extended (or truncated for narrow PCs) Instrucao[25:0]
    always_comb begin
        alvo = '0;
        for (int i = 0; i < LARGURA_END && i < ALVO_W; i++) begin
            alvo[i] = instrucao_i[i];
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (desvio_i) begin
            pc_d = destino_i;
        end else if (avanca_i) begin
            // PC+1 wraps naturally at the register width
            pc_d = eh_jump(instrucao_i) ? alvo : pc_q + UM;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= INIC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/unidade_busca.sv
// -----------------------------------------------------------------------------
// unidade_busca
// Instruction fetch stage: PC, fetched-instruction register, valid flag,
// fetch counter and a BUSCA/PARADO/HALT control FSM.
//   Clock         : single clock, rising edge
//   Reset         : synchronous active-high reset
//   Instrucao     : word read combinationally from instruction memory at Endereco
//   Parada        : stall request
//   Desvio        : redirect request (taken beq), priority over stall and jump
//   DestinoDesvio : redirect target
//   Endereco      : current PC
//   InstrucaoIF   : fetched instruction handed to decode
//   Valido        : InstrucaoIF holds a live instruction
//   Halted        : fetch stopped on a jump-to-self
//   ContadorBusca : saturating count of valid fetches
// Optional feature: define UNIDADE_BUSCA_HALT_DETECT_EN to stop fetching on a
// jump whose target is its own address. Without it Halted is tied low.
// -----------------------------------------------------------------------------
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int          LARGURA_END = 32,
    parameter int unsigned END_INICIAL = 0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [31:0]            Instrucao,
    input  logic                   Parada,
    input  logic                   Desvio,
    input  logic [LARGURA_END-1:0] DestinoDesvio,
    output logic [LARGURA_END-1:0] Endereco,
    output logic [31:0]            InstrucaoIF,
    output logic                   Valido,
    output logic                   Halted,
    output logic [31:0]            ContadorBusca
);

    estado_t     estado_q, estado_d;
    logic [31:0] instr_q, instr_d;
    logic        valido_q, valido_d;
    logic [31:0] cont_q, cont_d;
    logic        avanca;
    logic        desvio_pc;

    contador_programa #(
        .LARGURA_END (LARGURA_END),
        .END_INICIAL (END_INICIAL)
    ) u_pc (
        .clk_i       (Clock),
        .rst_i       (Reset),
        .avanca_i    (avanca),
        .desvio_i    (desvio_pc),
        .destino_i   (DestinoDesvio),
        .instrucao_i (Instrucao),
        .pc_o        (Endereco)
    );

`ifdef UNIDADE_BUSCA_HALT_DETECT_EN
    logic                   halted_q, halted_d;
    logic [LARGURA_END-1:0] alvo_self;
    logic                   salto_proprio;

    always_comb begin
        alvo_self = '0;
        for (int i = 0; i < LARGURA_END && i < ALVO_W; i++) begin
            alvo_self[i] = Instrucao[i];
        end
    end

    assign salto_proprio = eh_jump(Instrucao) && (alvo_self == Endereco);
`endif

    always_comb begin
        estado_d  = estado_q;
        instr_d   = instr_q;
        valido_d  = valido_q;
        cont_d    = cont_q;
        avanca    = 1'b0;
        desvio_pc = 1'b0;
`ifdef UNIDADE_BUSCA_HALT_DETECT_EN
        halted_d  = halted_q;
`endif
        unique case (estado_q)
            BUSCA: begin
                if (Desvio) begin
                    desvio_pc = 1'b1;
                    valido_d  = 1'b0;
                end else if (Parada) begin
                    estado_d = PARADO;
                end else begin
                    avanca   = 1'b1;
                    instr_d  = Instrucao;
                    valido_d = 1'b1;
                    cont_d   = incr_sat(cont_q);
`ifdef UNIDADE_BUSCA_HALT_DETECT_EN
                    // The self-jump is still delivered to decode once; PC
                    // reloads itself and stays there.
                    if (salto_proprio) begin
                        estado_d = HALT;
                        halted_d = 1'b1;
                    end
`endif
                end
            end
            PARADO: begin
                // Release only changes state; PC was held so the pending
                // fetch happens on the next edge and nothing is skipped.
                if (Desvio) begin
                    desvio_pc = 1'b1;
                    valido_d  = 1'b0;
                    estado_d  = BUSCA;
                end else if (!Parada) begin
                    estado_d = BUSCA;
                end
            end
            HALT: begin
                valido_d = 1'b0;
            end
            default: begin
                estado_d = BUSCA;
                valido_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q <= BUSCA;
            instr_q  <= '0;
            valido_q <= 1'b0;
            cont_q   <= '0;
`ifdef UNIDADE_BUSCA_HALT_DETECT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            instr_q  <= instr_d;
            valido_q <= valido_d;
            cont_q   <= cont_d;
`ifdef UNIDADE_BUSCA_HALT_DETECT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign InstrucaoIF   = instr_q;
    assign Valido        = valido_q;
    assign ContadorBusca = cont_q;
`ifdef UNIDADE_BUSCA_HALT_DETECT_EN
    assign Halted        = halted_q;
`else
    assign Halted        = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
module tb_unidade_busca;

    localparam logic [31:0] NOP = 32'h3000_0000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Instrucao;
    logic        Parada;
    logic        Desvio;
    logic [31:0] DestinoDesvio;
    logic [31:0] Endereco;
    logic [31:0] InstrucaoIF;
    logic        Valido;
    logic        Halted;
    logic [31:0] ContadorBusca;

    // Narrow instance for PC wrap and jump-target truncation
    logic        w_rst;
    logic [31:0] w_instr;
    logic        w_par;
    logic        w_desv;
    logic [3:0]  w_dest;
    logic [3:0]  w_end;
    logic [31:0] w_ir;
    logic        w_val;
    logic        w_halt;
    logic [31:0] w_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clock = ~Clock;

    unidade_busca dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Instrucao     (Instrucao),
        .Parada        (Parada),
        .Desvio        (Desvio),
        .DestinoDesvio (DestinoDesvio),
        .Endereco      (Endereco),
        .InstrucaoIF   (InstrucaoIF),
        .Valido        (Valido),
        .Halted        (Halted),
        .ContadorBusca (ContadorBusca)
    );

    unidade_busca #(.LARGURA_END(4)) dut4 (
        .Clock         (Clock),
        .Reset         (w_rst),
        .Instrucao     (w_instr),
        .Parada        (w_par),
        .Desvio        (w_desv),
        .DestinoDesvio (w_dest),
        .Endereco      (w_end),
        .InstrucaoIF   (w_ir),
        .Valido        (w_val),
        .Halted        (w_halt),
        .ContadorBusca (w_cnt)
    );

    typedef struct {
        logic        rst;
        logic        par;
        logic        desv;
        logic [31:0] dest;
        logic [31:0] instr;
        logic [31:0] e_end;
        logic        e_val;
        logic [31:0] e_ir;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic p, input logic d,
                       input logic [31:0] dst, input logic [31:0] ins,
                       input logic [31:0] ee, input logic ev,
                       input logic [31:0] eir, input logic [31:0] ec);
        vec_t v;
        v.rst = r; v.par = p; v.desv = d; v.dest = dst; v.instr = ins;
        v.e_end = ee; v.e_val = ev; v.e_ir = eir; v.e_cnt = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic p, input logic d,
                        input logic [31:0] dst, input logic [31:0] ins);
        Reset = r; Parada = p; Desvio = d; DestinoDesvio = dst; Instrucao = ins;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ee, input logic ev,
                           input logic [31:0] eir, input logic [31:0] ec, input logic eh);
        chk({tag, " Endereco"},      Endereco,             ee);
        chk({tag, " Valido"},        {31'd0, Valido},      {31'd0, ev});
        chk({tag, " InstrucaoIF"},   InstrucaoIF,          eir);
        chk({tag, " ContadorBusca"}, ContadorBusca,        ec);
        chk({tag, " Halted"},        {31'd0, Halted},      {31'd0, eh});
    endtask

    initial begin
        Reset = 1'b1; Parada = 1'b0; Desvio = 1'b0; DestinoDesvio = '0; Instrucao = NOP;
        w_rst = 1'b1; w_par = 1'b0; w_desv = 1'b0; w_dest = '0; w_instr = NOP;

        // rst par desv dest instr | Endereco Valido InstrucaoIF Contador
        add(1, 0, 0, 0,  NOP,          0,  0, 32'h0,        0);
        add(1, 0, 0, 0,  NOP,          0,  0, 32'h0,        0);
        add(0, 0, 0, 0,  NOP,          1,  1, NOP,          1);
        add(0, 0, 0, 0,  NOP,          2,  1, NOP,          2);
        add(0, 0, 0, 0,  NOP,          3,  1, NOP,          3);
        add(0, 0, 0, 0,  NOP,          4,  1, NOP,          4);
        add(0, 0, 1, 7,  NOP,          7,  0, NOP,          4);
        add(0, 0, 0, 0,  32'h30000007, 8,  1, 32'h30000007, 5);
        add(0, 1, 0, 0,  32'h30000008, 8,  1, 32'h30000007, 5);
        add(0, 1, 0, 0,  32'h30000008, 8,  1, 32'h30000007, 5);
        add(0, 1, 0, 0,  32'h30000008, 8,  1, 32'h30000007, 5);
        add(0, 0, 0, 0,  32'h30000008, 8,  1, 32'h30000007, 5);
        add(0, 0, 0, 0,  32'h30000008, 9,  1, 32'h30000008, 6);
        add(0, 0, 1, 14, 32'h30000009, 14, 0, 32'h30000008, 6);
        add(0, 0, 0, 0,  32'h14000012, 18, 1, 32'h14000012, 7);
        add(0, 1, 1, 15, 32'h14000012, 15, 0, 32'h14000012, 7);
        add(0, 0, 0, 0,  NOP,          16, 1, NOP,          8);
        add(0, 1, 0, 0,  NOP,          16, 1, NOP,          8);
        add(0, 1, 1, 3,  NOP,          3,  0, NOP,          8);
        add(0, 0, 0, 0,  NOP,          4,  1, NOP,          9);
        add(0, 1, 0, 0,  NOP,          4,  1, NOP,          9);
        add(1, 1, 0, 0,  NOP,          0,  0, 32'h0,        0);
        add(0, 0, 0, 0,  NOP,          1,  1, NOP,          1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].par, tbl[i].desv, tbl[i].dest, tbl[i].instr);
            chk_all($sformatf("vec%0d", i), tbl[i].e_end, tbl[i].e_val,
                    tbl[i].e_ir, tbl[i].e_cnt, 1'b0);
        end

        // Jump-to-self at 22
        step(0, 0, 1, 22, NOP);
        chk_all("to22", 22, 0, NOP, 1, 0);
`ifdef UNIDADE_BUSCA_HALT_DETECT_EN
        step(0, 0, 0, 0, 32'h14000016);
        chk_all("halt_entry", 22, 1, 32'h14000016, 2, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, (i == 6), (i == 4), 5, 32'h14000016);
            chk_all($sformatf("halt%0d", i), 22, 0, 32'h14000016, 2, 1);
        end
        step(1, 0, 0, 0, NOP);
        chk_all("halt_reset", 0, 0, 32'h0, 0, 0);
`else
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 32'h14000016);
            chk_all($sformatf("selfjmp%0d", i), 22, 1, 32'h14000016, 32'(2 + i), 0);
        end
        step(0, 0, 1, 5, 32'h14000016);
        chk_all("selfjmp_exit", 5, 0, 32'h14000016, 4, 0);
        step(1, 0, 0, 0, NOP);
        chk_all("selfjmp_reset", 0, 0, 32'h0, 0, 0);
`endif

        // 4-bit PC: wrap 15 -> 0 and truncated jump target
        Reset = 1'b1;
        w_rst = 1'b1;
        @(posedge Clock); #1;
        chk("w4 reset Endereco", {28'd0, w_end}, 32'd0);
        w_rst = 1'b0; w_desv = 1'b1; w_dest = 4'd15;
        @(posedge Clock); #1;
        chk("w4 redirect Endereco", {28'd0, w_end}, 32'd15);
        chk("w4 redirect Valido", {31'd0, w_val}, 32'd0);
        w_desv = 1'b0; w_instr = NOP;
        @(posedge Clock); #1;
        chk("w4 wrap Endereco", {28'd0, w_end}, 32'd0);
        chk("w4 wrap Valido", {31'd0, w_val}, 32'd1);
        chk("w4 wrap ContadorBusca", w_cnt, 32'd1);
        w_instr = 32'h14000012;
        @(posedge Clock); #1;
        chk("w4 jump Endereco", {28'd0, w_end}, 32'd2);
        chk("w4 jump InstrucaoIF", w_ir, 32'h14000012);
        chk("w4 Halted", {31'd0, w_halt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
